// File: rtl/cafea_dispense_ctrl.sv
// Coffee machine dispense sequencer: drops cups, runs the brew pump and ejects
// change coins for one settled sale at a time, refunding in coins when the cup
// magazine is empty.
module cafea_dispense_ctrl #(
    parameter int unsigned CUP_CYCLES  = 4,
    parameter int unsigned BREW_CYCLES = 8,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned COIN_PULSE  = 3,
    parameter int unsigned COIN_GAP    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [1:0] req_cups_i,
    input  logic [1:0] req_change_i,
    input  logic       cup_empty_i,
    output logic       cup_drop_o,
    output logic       pump_on_o,
    output logic       coin_eject_o,
    output logic       done_o,
    output logic       fault_o
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CUPS_W  = 2;
    localparam int unsigned COINS_W = 4;

    // Counters count down to zero, so each state is loaded with its length minus one.
    localparam logic [CNT_W-1:0] CUP_LD   = CNT_W'(CUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BREW_LD  = CNT_W'(BREW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] CGAP_LD  = CNT_W'(COIN_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CUP,
        S_BREW,
        S_GAP,
        S_COIN_ON,
        S_COIN_OFF,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CUPS_W-1:0]    cups_q, cups_d;
    logic [COINS_W-1:0]   coins_q, coins_d;
    logic                 fault_q, fault_d;

    logic [CUPS_W-1:0]    dec_cups_in;
    logic [COINS_W-1:0]   dec_coins_in;
    state_e               dec_state;
    logic [CNT_W-1:0]     dec_cnt;
    logic [CUPS_W-1:0]    dec_cups;
    logic [COINS_W-1:0]   dec_coins;
    logic                 dec_refund;

    logic                 cnt_zero;
    assign cnt_zero = (cnt_q == '0);

    // Work remaining at a decision point: fresh request when idle, latched counts after a gap.
    always_comb begin
        dec_cups_in  = cups_q;
        dec_coins_in = coins_q;
        if (state_q == S_IDLE) begin
            dec_cups_in  = req_cups_i;
            dec_coins_in = COINS_W'(req_change_i);
        end
    end

    // Decision point: brew the next cup, refund everything in coins, pay change, or finish.
    always_comb begin
        dec_state  = S_DONE;
        dec_cnt    = '0;
        dec_cups   = dec_cups_in;
        dec_coins  = dec_coins_in;
        dec_refund = 1'b0;
        if (dec_cups_in != '0 && !cup_empty_i) begin
            dec_state = S_CUP;
            dec_cnt   = CUP_LD;
        end else if (dec_cups_in != '0) begin
            dec_refund = 1'b1;
            dec_cups   = '0;
            dec_coins  = dec_coins_in + COINS_W'(dec_cups_in) * COINS_W'(3);
            dec_state  = S_COIN_ON;
            dec_cnt    = PULSE_LD;
        end else if (dec_coins_in != '0) begin
            dec_state = S_COIN_ON;
            dec_cnt   = PULSE_LD;
        end
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cups_d  = cups_q;
        coins_d = coins_q;
        fault_d = fault_q;
        if (!cnt_zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = dec_state;
                    cnt_d   = dec_cnt;
                    cups_d  = dec_cups;
                    coins_d = dec_coins;
                    fault_d = dec_refund;
                end
            end
            S_CUP: begin
                if (cnt_zero) begin
                    state_d = S_BREW;
                    cnt_d   = BREW_LD;
                end
            end
            S_BREW: begin
                if (cnt_zero) begin
                    cups_d = cups_q - CUPS_W'(1);
                    if (cups_q > CUPS_W'(1)) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LD;
                    end else if (coins_q != '0) begin
                        state_d = S_COIN_ON;
                        cnt_d   = PULSE_LD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_d = dec_state;
                    cnt_d   = dec_cnt;
                    cups_d  = dec_cups;
                    coins_d = dec_coins;
                    if (dec_refund) begin
                        fault_d = 1'b1;
                    end
                end
            end
            S_COIN_ON: begin
                if (cnt_zero) begin
                    coins_d = coins_q - COINS_W'(1);
                    state_d = S_COIN_OFF;
                    cnt_d   = CGAP_LD;
                end
            end
            S_COIN_OFF: begin
                if (cnt_zero) begin
                    if (coins_q != '0) begin
                        state_d = S_COIN_ON;
                        cnt_d   = PULSE_LD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cups_q  <= '0;
            coins_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cups_q  <= cups_d;
            coins_q <= coins_d;
            fault_q <= fault_d;
        end
    end

    // Actuator and handshake outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready_o  <= 1'b1;
            cup_drop_o   <= 1'b0;
            pump_on_o    <= 1'b0;
            coin_eject_o <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            req_ready_o  <= (state_d == S_IDLE);
            cup_drop_o   <= (state_d == S_CUP);
            pump_on_o    <= (state_d == S_BREW);
            coin_eject_o <= (state_d == S_COIN_ON);
            done_o       <= (state_d == S_DONE);
        end
    end

    assign fault_o = fault_q;

endmodule

// File: tb/tb_cafea_dispense_ctrl.sv
// Directed bench for the dispense sequencer: a cycle-level model pushes the
// expected output vector of every cycle of a request into a queue, and each
// cycle after the accept edge one entry is popped and compared.
module tb_cafea_dispense_ctrl;

    localparam int CUP  = 4;
    localparam int BREW = 8;
    localparam int GAP  = 2;
    localparam int PUL  = 3;
    localparam int CGAP = 2;
    localparam int NEVER = 100000;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cups;
    logic [1:0] req_change;
    logic       cup_empty;
    logic       cup_drop;
    logic       pump_on;
    logic       coin_eject;
    logic       done;
    logic       fault;

    int checks = 0;
    int errors = 0;

    // {ready, cup_drop, pump_on, coin_eject, done, fault}
    typedef logic [5:0] vec_t;
    vec_t exp_q[$];

    cafea_dispense_ctrl #(
        .CUP_CYCLES (CUP),
        .BREW_CYCLES(BREW),
        .GAP_CYCLES (GAP),
        .COIN_PULSE (PUL),
        .COIN_GAP   (CGAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_cups_i  (req_cups),
        .req_change_i(req_change),
        .cup_empty_i (cup_empty),
        .cup_drop_o  (cup_drop),
        .pump_on_o   (pump_on),
        .coin_eject_o(coin_eject),
        .done_o      (done),
        .fault_o     (fault)
    );

    always #5 clk = ~clk;

    function automatic vec_t obs();
        return {req_ready, cup_drop, pump_on, coin_eject, done, fault};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_n(input vec_t v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Expected per-cycle trace; cup magazine reads empty from cycle e_from on
    // (cycle 0 is the cycle ending in the accept edge).
    task automatic model(input int cups, input int change, input int e_from);
        int   n     = cups;
        int   coins = change;
        int   t     = 1;
        int   dk    = 0;
        logic f     = 1'b0;
        while (n > 0) begin
            if (dk >= e_from) begin
                coins = coins + 3 * n;
                n     = 0;
                f     = 1'b1;
            end else begin
                push_n(vec_t'({5'b01000, f}), CUP);  t += CUP;
                push_n(vec_t'({5'b00100, f}), BREW); t += BREW;
                n--;
                if (n > 0) begin
                    push_n(vec_t'({5'b00000, f}), GAP); t += GAP;
                    dk = t - 1;
                end
            end
        end
        for (int c = 0; c < coins; c++) begin
            push_n(vec_t'({5'b00010, f}), PUL);
            push_n(vec_t'({5'b00000, f}), CGAP);
        end
        push_n(vec_t'({5'b00001, f}), 1);
        push_n(vec_t'({5'b10000, f}), 1);
    endtask

    // Issue one request and compare every cycle until the trace is consumed;
    // with hold set, req_valid stays high and request inputs change while busy.
    task automatic run(input string tag, input int cups, input int change,
                       input int e_from, input bit hold);
        int   k = 0;
        vec_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_cups   = 2'(cups);
        req_change = 2'(change);
        cup_empty  = (e_from <= 0);
        model(cups, change, e_from);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            k++;
            if (k > 2000) begin
                check({tag, "_timeout"}, 32'(k), 32'(0));
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            check($sformatf("%s_c%0d", tag, k), 32'(obs()), 32'(e));
            if (!hold) begin
                req_valid = 1'b0;
            end else begin
                req_cups   = 2'd3;
                req_change = 2'd3;
                if (e[1]) req_valid = 1'b0;
            end
            cup_empty = (k >= e_from);
        end
        req_valid = 1'b0;
        cup_empty = 1'b0;
    endtask

    initial begin
        int done_cnt;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_cups   = '0;
        req_change = '0;
        cup_empty  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(obs()), 32'(6'b100000));
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'(obs()), 32'(6'b100000));

        run("t1_c1_ch0", 1, 0, NEVER, 1'b0);
        run("t2_c2_ch1", 2, 1, NEVER, 1'b0);
        run("t3_c0_ch2", 0, 2, NEVER, 1'b0);
        run("t4_empty",  1, 1, 0, 1'b0);
        repeat (5) @(negedge clk);
        check("t4_fault_sticky", 32'(fault), 32'(1));
        run("t5_empty_mid", 2, 0, 7, 1'b0);
        run("t5b_c3_ch3", 3, 3, NEVER, 1'b0);
        run("t5c_empty_c3", 3, 2, 16, 1'b0);

        // Reset mid-brew aborts without a done pulse.
        @(negedge clk);
        req_valid = 1'b1; req_cups = 2'd1; req_change = 2'd0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_in_brew", 32'(obs()), 32'(6'b001000));
        reset = 1'b1;
        @(negedge clk);
        check("t6_reset_abort", 32'(obs()), 32'(6'b100000));
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("t6_no_done", 32'(done_cnt), 32'(0));
        check("t6_still_idle", 32'(obs()), 32'(6'b100000));
        run("t6_c0_ch0", 0, 0, NEVER, 1'b0);
        run("t6_hold_valid", 1, 1, NEVER, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
